// File: rtl/spi_shifter.sv
// SPI datapath stage: holds one CPU tx word, shifts it out on MOSI and assembles the MISO word.
// Optional macro SPI_LSB_FIRST_EN selects LSB-first shifting; the default build is MSB-first.
module spi_shifter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [3:0]        xfer_len,
  input  logic              i_load,
  input  logic              i_en,
  input  logic              tbuf_mosi_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              overrun,
  output logic              underrun,
  output logic              mosi,
  output logic              mosi_oe,
  input  logic              miso
);

  logic              full;
  logic [DATA_W-1:0] hold;
  logic              i_load_q;
  logic              sck_q;
  logic [DATA_W-1:0] shift_reg;
  logic [3:0]        len_q;
  logic [4:0]        tx_cnt;
  logic [4:0]        rx_cnt;
  logic [DATA_W-1:0] rx_shift;

  logic [4:0]        nbits;
  logic              sck_edge;
  logic              lead;
  logic              drive_edge;
  logic              sample_edge;
  logic              load_fall;
  logic              tx_take;
  logic              complete;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] tx_next;
  logic [DATA_W-1:0] rx_mask;

  // Edges are ignored while the controller holds i_load; counters saturate at nbits.
  always_comb begin
    nbits       = {1'b0, len_q} + 5'd1;
    sck_edge    = (sck != sck_q) && !i_load;
    lead        = (sck != cpol);
    drive_edge  = sck_edge && (cpha ? lead : !lead) && i_en && (tx_cnt < nbits);
    sample_edge = sck_edge && (cpha ? !lead : lead) && (rx_cnt < nbits);
    load_fall   = i_load_q && !i_load;
    tx_take     = tx_valid && !full;
    complete    = sample_edge && (rx_cnt == nbits - 5'd1);
    rx_mask     = ~({DATA_W{1'b1}} << nbits);
`ifdef SPI_LSB_FIRST_EN
    tx_next         = shift_reg >> 1;
    rx_next         = rx_shift >> 1;
    rx_next[len_q]  = miso;
`else
    tx_next         = shift_reg << 1;
    rx_next         = {rx_shift[DATA_W-2:0], miso};
`endif
  end

  assign tx_ready = !full;
  assign mosi_oe  = tbuf_mosi_oe;
`ifdef SPI_LSB_FIRST_EN
  assign mosi     = shift_reg[0];
`else
  assign mosi     = shift_reg[len_q];
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full      <= 1'b0;
      hold      <= '0;
      i_load_q  <= 1'b0;
      sck_q     <= cpol;
      shift_reg <= '0;
      len_q     <= '0;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      i_load_q <= i_load;
      sck_q    <= sck;
      underrun <= load_fall && !full;

      // A new handshake takes priority; it can only coincide with a fall when already empty.
      if (tx_take) begin
        full <= 1'b1;
        hold <= tx_data;
      end else if (load_fall) begin
        full <= 1'b0;
      end

      if (i_load) begin
        shift_reg <= full ? hold : '1;
        len_q     <= xfer_len;
        tx_cnt    <= '0;
        rx_cnt    <= '0;
      end else begin
        if (drive_edge) begin
          shift_reg <= tx_next;
          tx_cnt    <= tx_cnt + 5'd1;
        end
        if (sample_edge) begin
          rx_shift <= rx_next;
          rx_cnt   <= rx_cnt + 5'd1;
        end
      end

      if (complete) begin
        rx_data  <= rx_next & rx_mask;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end

      if (rx_ack) begin
        overrun <= 1'b0;
      end else if (complete && rx_valid) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_shifter.sv
// Self-checking bench for spi_shifter: emulates the SPI controller and compares against a word-level model.
module tb_spi_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        sck, cpol, cpha;
  logic [3:0]  xfer_len;
  logic        i_load, i_en, tbuf_mosi_oe;
  logic [15:0] tx_data;
  logic        tx_valid, tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid, rx_ack, overrun, underrun;
  logic        mosi, mosi_oe, miso;

  spi_shifter #(.DATA_W(16)) dut (
    .clk(clk), .rst(rst), .sck(sck), .cpol(cpol), .cpha(cpha), .xfer_len(xfer_len),
    .i_load(i_load), .i_en(i_en), .tbuf_mosi_oe(tbuf_mosi_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .overrun(overrun), .underrun(underrun),
    .mosi(mosi), .mosi_oe(mosi_oe), .miso(miso)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int underrun_cycles = 0;
  logic chk_en = 1'b0;
  logic ready_after_fall;

  // Model state: transfer tracked as a loaded word, count of drive edges and list of sampled bits.
  logic        exp_full, exp_rx_valid, exp_overrun, exp_underrun, exp_mosi;
  logic [15:0] exp_hold, exp_rx_data, m_word;
  logic [3:0]  m_len;
  int          m_k, m_nrx;
  logic        m_bits [16];
  logic        m_load_q, m_sck_q;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_full = 0; exp_hold = '0; m_word = '0; m_len = '0; m_k = 0; m_nrx = 0;
    exp_rx_valid = 0; exp_rx_data = '0; exp_overrun = 0; exp_underrun = 0; exp_mosi = 0;
    m_load_q = 0; m_sck_q = cpol;
  endtask

  // Advance one clock and apply the spec rules to the inputs that were present at that edge.
  task automatic tick();
    logic        pre_full, fall, edge_seen, lead, drv, smp, done;
    logic [15:0] pre_hold, w;
    int          n;
    pre_full = exp_full;
    pre_hold = exp_hold;
    @(posedge clk);
    #1;
    if (!rst) return;
    exp_underrun = 0;
    n = int'(m_len) + 1;
    fall = m_load_q && !i_load;
    edge_seen = (sck != m_sck_q) && !i_load;
    lead = (sck != cpol);
    drv = edge_seen && (cpha ? lead : !lead);
    smp = edge_seen && (cpha ? !lead : lead);
    done = 0;
    if (drv && i_en && m_k < n) m_k++;
    if (smp && m_nrx < n) begin
      m_bits[m_nrx] = miso;
      m_nrx++;
      done = (m_nrx == n);
    end
    if (done) begin
      w = '0;
      for (int i = 0; i < n; i++) w[n-1-i] = m_bits[i];
      exp_rx_data = w;
      exp_overrun = rx_ack ? 1'b0 : (exp_rx_valid ? 1'b1 : exp_overrun);
      exp_rx_valid = 1;
    end else if (rx_ack) begin
      exp_rx_valid = 0;
      exp_overrun = 0;
    end
    if (i_load) begin
      m_word = pre_full ? pre_hold : 16'hFFFF;
      m_k = 0;
      m_nrx = 0;
      m_len = xfer_len;
    end
    if (tx_valid && !pre_full) begin
      exp_full = 1;
      exp_hold = tx_data;
    end else if (fall) begin
      exp_full = 0;
    end
    if (fall && !pre_full) exp_underrun = 1;
    m_load_q = i_load;
    m_sck_q = sck;
    exp_mosi = (m_k <= int'(m_len)) ? m_word[int'(m_len) - m_k] : 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx_ready", {15'd0, tx_ready}, {15'd0, !exp_full});
      check("rx_valid", {15'd0, rx_valid}, {15'd0, exp_rx_valid});
      check("rx_data", rx_data, exp_rx_data);
      check("overrun", {15'd0, overrun}, {15'd0, exp_overrun});
      check("underrun", {15'd0, underrun}, {15'd0, exp_underrun});
      check("mosi", {15'd0, mosi}, {15'd0, exp_mosi});
      check("mosi_oe", {15'd0, mosi_oe}, {15'd0, tbuf_mosi_oe});
    end
    if (underrun === 1'b1) underrun_cycles++;
  end

  // Controller emulation: load, release, then nbits sck periods of two clocks per half.
  task automatic xfer(input logic p_cpol, input logic p_cpha, input logic [3:0] p_len,
                      input logic do_tx, input logic [15:0] word, input logic loop,
                      input logic miso_c, input logic ack_last, input int nbits,
                      output logic [15:0] seq);
    int n;
    bit samp;
    n = int'(p_len) + 1;
    seq = '0;
    cpol = p_cpol; cpha = p_cpha; sck = p_cpol; xfer_len = p_len;
    i_load = 1; i_en = 0; tbuf_mosi_oe = 0;
    tick(); tick();
    if (do_tx) begin
      tx_valid = 1; tx_data = word;
      tick();
      tx_valid = 0;
    end
    tick();
    i_load = 0; i_en = 1; tbuf_mosi_oe = 1;
    tick();
    ready_after_fall = tx_ready;
    for (int i = 0; i < nbits; i++) begin
      for (int h = 0; h < 2; h++) begin
        samp = (h == 0) ? !p_cpha : p_cpha;
        if (samp) begin
          miso = loop ? exp_mosi : miso_c;
          seq = {seq[14:0], mosi};
          if (ack_last && i == n - 1) rx_ack = 1;
        end
        sck = (h == 0) ? ~p_cpol : p_cpol;
        tick();
        rx_ack = 0;
        tick();
      end
    end
    if (nbits == n) begin
      i_en = 0; tbuf_mosi_oe = 0; i_load = 1;
      tick(); tick();
    end
  endtask

  task automatic ack();
    rx_ack = 1;
    tick();
    rx_ack = 0;
  endtask

  logic [15:0] seq;
  int u0;

  initial begin
    rst = 0; cpol = 0; cpha = 0; sck = 0; xfer_len = 4'd7;
    i_load = 1; i_en = 0; tbuf_mosi_oe = 0;
    tx_data = '0; tx_valid = 0; rx_ack = 0; miso = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_tx_ready", {15'd0, tx_ready}, 16'd1);
    check("reset_rx_valid", {15'd0, rx_valid}, 16'd0);
    check("reset_rx_data", rx_data, 16'h0000);
    check("reset_flags", {14'd0, overrun, underrun}, 16'd0);
    check("reset_mosi", {15'd0, mosi}, 16'd0);
    chk_en = 1;
    rst = 1;

    // Mode 0, 8 bits, loopback.
    xfer(0, 0, 4'd7, 1, 16'h00A5, 1, 0, 0, 8, seq);
    check("t1_mosi_seq", seq, 16'h00A5);
    check("t1_rx_data", rx_data, 16'h00A5);
    check("t1_rx_valid", {15'd0, rx_valid}, 16'd1);
    ack();

    // Mode 3, 16 bits, miso tied high.
    xfer(1, 1, 4'd15, 1, 16'h1234, 0, 1, 0, 16, seq);
    check("t2_ready_at_fall", {15'd0, ready_after_fall}, 16'd1);
    check("t2_rx_data", rx_data, 16'hFFFF);
    ack();

    // Back-to-back without ack.
    xfer(0, 0, 4'd7, 1, 16'h003C, 1, 0, 0, 8, seq);
    xfer(0, 0, 4'd7, 1, 16'h00C3, 1, 0, 0, 8, seq);
    check("t3_overrun", {15'd0, overrun}, 16'd1);
    check("t3_rx_data", rx_data, 16'h00C3);
    ack();
    check("t3_ack_valid", {15'd0, rx_valid}, 16'd0);
    check("t3_ack_overrun", {15'd0, overrun}, 16'd0);

    // Empty holding register, 4 bits.
    u0 = underrun_cycles;
    xfer(0, 0, 4'd3, 0, 16'h0000, 1, 0, 0, 4, seq);
    check("t4_underrun_cycles", 16'(underrun_cycles - u0), 16'd1);
    check("t4_mosi_seq", seq, 16'h000F);
    check("t4_rx_data", rx_data, 16'h000F);
    ack();

    // Ack coincident with completion of a second word.
    xfer(0, 0, 4'd7, 1, 16'h005A, 1, 0, 0, 8, seq);
    xfer(0, 0, 4'd7, 1, 16'h0081, 1, 0, 1, 8, seq);
    check("t6_rx_valid", {15'd0, rx_valid}, 16'd1);
    check("t6_overrun", {15'd0, overrun}, 16'd0);
    check("t6_rx_data", rx_data, 16'h0081);

    // Reset after 3 bits with a word pending and a new word held.
    xfer(0, 0, 4'd7, 1, 16'h0096, 1, 0, 0, 3, seq);
    tx_valid = 1; tx_data = 16'h0077;
    tick();
    tx_valid = 0;
    check("t5_pre_ready", {15'd0, tx_ready}, 16'd0);
    rst = 0;
    i_load = 1; i_en = 0; tbuf_mosi_oe = 0; sck = cpol;
    model_reset();
    #1;
    check("t5_rst_tx_ready", {15'd0, tx_ready}, 16'd1);
    check("t5_rst_rx_valid", {15'd0, rx_valid}, 16'd0);
    check("t5_rst_mosi", {15'd0, mosi}, 16'd0);
    tick();
    rst = 1;
    xfer(0, 0, 4'd7, 1, 16'h0069, 1, 0, 0, 8, seq);
    check("t5_mosi_seq", seq, 16'h0069);
    check("t5_rx_data", rx_data, 16'h0069);
    ack();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
